// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg                                                                    |
// | Shared widths, reset PC and fetch-state encoding for the 16-bit CPU.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    localparam int PC_WIDTH    = 16;
    localparam int INSTR_WIDTH = 16;
    localparam int PC_STEP     = 2;
    localparam logic [PC_WIDTH-1:0] RESET_PC = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_DISCARD = 3'd3,
        ST_FAULT   = 3'd4
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_next_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_next_adder                                                              |
// | Combinational ripple incrementer: pc_out = pc_in + STEP, modulo 2^WIDTH.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_next_adder #(
    parameter int WIDTH = 16,
    parameter int STEP  = 2
) (
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out,
    output logic             cout
);

    localparam logic [WIDTH-1:0] c_step = WIDTH'(STEP);

    logic [WIDTH-1:0] w_sum;
    logic             w_carry;

    // Carry is walked as a single variable so the chain stays one combinational path.
    always_comb begin
        w_sum   = '0;
        w_carry = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i] = pc_in[i] ^ c_step[i] ^ w_carry;
            w_carry  = (pc_in[i] & c_step[i]) | (w_carry & (pc_in[i] ^ c_step[i]));
        end
    end

    assign pc_out = w_sum;
    assign cout   = w_carry;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch_unit                                                              |
// | Instruction-fetch front end: PC register, req/ack imem fetch, valid/ready  |
// | hand-off to decode, redirect handling with stale-response discard.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH    = cpu_pkg::PC_WIDTH,
    parameter int                  INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = cpu_pkg::RESET_PC,
    parameter int                  PC_STEP     = cpu_pkg::PC_STEP
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   id_ready,
    output logic                   fetch_fault
);

    fetch_state_t           r_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [PC_WIDTH-1:0]    r_pend_pc;
    logic                   r_instr_valid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_instr_pc;
    logic                   r_fetch_fault;

    logic [PC_WIDTH-1:0]    w_pc_plus;
    logic                   w_unused_cout;

    pc_next_adder #(
        .WIDTH (PC_WIDTH),
        .STEP  (PC_STEP)
    ) u_pc_next_adder (
        .pc_in  (r_pc),
        .pc_out (w_pc_plus),
        .cout   (w_unused_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_pend_pc     <= '0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_fetch_fault <= 1'b0;
        end else if (redirect && redirect_pc[0]) begin
            // A misaligned target poisons the front end until the next reset.
            r_state       <= ST_FAULT;
            r_instr_valid <= 1'b0;
            r_fetch_fault <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            r_pc <= redirect_pc;
                        end else begin
                            r_instr       <= imem_rdata;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_pc          <= w_pc_plus;
                            r_state       <= ST_HOLD;
                        end
                    end else if (redirect) begin
                        // Address must stay stable until the in-flight request is acked.
                        r_pend_pc <= redirect_pc;
                        r_state   <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (imem_ack) begin
                        r_pc    <= redirect ? redirect_pc : r_pend_pc;
                        r_state <= ST_FETCH;
                    end else if (redirect) begin
                        r_pend_pc <= redirect_pc;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        r_instr_valid <= 1'b0;
                        r_pc          <= redirect_pc;
                        r_state       <= ST_FETCH;
                    end else if (id_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_FETCH;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == ST_FETCH) || (r_state == ST_DISCARD);
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign fetch_fault = r_fetch_fault;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_fetch_unit                                                           |
// | Directed scenarios plus randomized traffic against a flag-based model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pc_fetch_unit;

    localparam logic [15:0] C_RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        id_ready = 1'b0;
    logic        fetch_fault;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .PC_WIDTH    (16),
        .INSTR_WIDTH (16),
        .RESET_PC    (C_RESET_PC),
        .PC_STEP     (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .id_ready    (id_ready),
        .fetch_fault (fetch_fault)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: is a request outstanding, is it stale (and where to go after), is a word held.
    bit          m_req, m_stale, m_valid, m_fault;
    logic [15:0] m_pc, m_target, m_instr, m_ipc;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clk();
        if (!rst_n) begin
            m_req = 0; m_stale = 0; m_valid = 0; m_fault = 0;
            m_pc = C_RESET_PC; m_target = 16'h0; m_instr = 16'h0; m_ipc = 16'h0;
        end else if (m_fault) begin
            m_req = 0;
        end else if (redirect && redirect_pc[0]) begin
            m_fault = 1; m_valid = 0; m_req = 0; m_stale = 0;
        end else if (m_req) begin
            if (imem_ack) begin
                if (redirect) begin
                    m_pc = redirect_pc; m_stale = 0;
                end else if (m_stale) begin
                    m_pc = m_target; m_stale = 0;
                end else begin
                    m_instr = imem_rdata; m_ipc = m_pc; m_valid = 1; m_req = 0;
                    m_pc = 16'((int'(m_pc) + 2) % 65536);
                end
            end else if (redirect) begin
                m_stale = 1; m_target = redirect_pc;
            end
        end else if (m_valid) begin
            if (redirect) begin
                m_valid = 0; m_pc = redirect_pc; m_req = 1;
            end else if (id_ready) begin
                m_valid = 0; m_req = 1;
            end
        end else begin
            m_req = 1;
        end
    endtask

    task automatic compare_all();
        check("imem_req",    {15'h0, imem_req},    {15'h0, m_req});
        check("imem_addr",   imem_addr,            m_pc);
        check("instr_valid", {15'h0, instr_valid}, {15'h0, m_valid});
        check("instr",       instr,                m_instr);
        check("instr_pc",    instr_pc,             m_ipc);
        check("fetch_fault", {15'h0, fetch_fault}, {15'h0, m_fault});
    endtask

    task automatic step(input logic r, input logic a, input logic rd,
                        input logic [15:0] rpc, input logic idr);
        @(negedge clk);
        rst_n       = r;
        imem_ack    = a;
        redirect    = rd;
        redirect_pc = rpc;
        id_ready    = idr;
        imem_rdata  = 16'($urandom);
        @(posedge clk);
        model_clk();
        #1;
        compare_all();
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] rpc;

        // Reset and straight-line fetch with immediate consume
        step(0, 0, 0, 16'h0, 1);
        step(0, 0, 0, 16'h0, 1);
        check("rst_req", {15'h0, imem_req}, 16'h0000);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 16'h0, 1);

        // Decode stall in HOLD, then release
        for (int i = 0; i < 8; i++) step(1, 1, 0, 16'h0, 0);
        check("stall_req", {15'h0, imem_req}, 16'h0000);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 16'h0, 1);

        // Redirect while a request at 0x0008 is unacked
        step(0, 0, 0, 16'h0, 1);
        for (int i = 0; i < 40 && !(m_req && m_pc == 16'h0008); i++) step(1, 1, 0, 16'h0, 1);
        check("t3_req_at_8", imem_addr, 16'h0008);
        step(1, 0, 1, 16'h0040, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 16'h0, 1);
            check("t3_addr_held", imem_addr, 16'h0008);
        end
        step(1, 1, 0, 16'h0, 1);
        check("t3_new_addr", imem_addr, 16'h0040);
        check("t3_stale_invalid", {15'h0, instr_valid}, 16'h0000);

        // Redirect in HOLD beats a simultaneous id_ready
        for (int i = 0; i < 10 && !m_valid; i++) step(1, 1, 0, 16'h0, 0);
        step(1, 0, 1, 16'h0100, 1);
        check("t4_flushed", {15'h0, instr_valid}, 16'h0000);
        check("t4_addr", imem_addr, 16'h0100);

        // PC wrap from 0xFFFE
        step(1, 0, 1, 16'hFFFE, 0);
        step(1, 1, 0, 16'h0, 0);
        step(1, 1, 0, 16'h0, 0);
        check("t5_ipc", instr_pc, 16'hFFFE);
        step(1, 0, 0, 16'h0, 1);
        check("t5_wrap_addr", imem_addr, 16'h0000);
        check("t5_no_fault", {15'h0, fetch_fault}, 16'h0000);

        // Misaligned redirect, sticky fault, reset recovery
        step(1, 0, 1, 16'h0013, 1);
        check("t6_fault", {15'h0, fetch_fault}, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            step(1, 1'($urandom), 0, 16'h0, 1);
            check("t6_req_low", {15'h0, imem_req}, 16'h0000);
        end
        step(0, 0, 0, 16'h0, 1);
        check("t6_rst_fault", {15'h0, fetch_fault}, 16'h0000);
        step(1, 0, 0, 16'h0, 1);
        check("t6_restart", imem_addr, C_RESET_PC);

        // Randomized traffic including spurious acks, wrap targets and occasional faults
        for (int i = 0; i < 4000; i++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 39) == 0)      rpc = {v[15:1], 1'b1};
            else if ($urandom_range(0, 7) == 0)  rpc = 16'hFFFE;
            else                                 rpc = {v[15:1], 1'b0};
            step(($urandom_range(0, 149) != 0),
                 ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 9) == 0),
                 rpc,
                 ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
